// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, drives the external 9-bit shift
// register through its start/shift control pair and times every bit on the line.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [8:0] xmt_shift_reg,
    output logic       start,
    output logic       shift,
    input  logic       shifted_lsb,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DATA = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [3:0]          r_bit_cnt;
    logic [8:0]          r_xmt_shift_reg;
    logic                r_tx_done;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [3:0]          w_bit_nxt;
    logic [8:0]          w_xsr_nxt;
    logic                w_done_nxt;

    // State, counters, load value and completion pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_baud_cnt      <= BAUD_ZERO;
            r_bit_cnt       <= 4'd0;
            r_xmt_shift_reg <= 9'h000;
            r_tx_done       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_baud_cnt      <= w_baud_nxt;
            r_bit_cnt       <= w_bit_nxt;
            r_xmt_shift_reg <= w_xsr_nxt;
            r_tx_done       <= w_done_nxt;
        end
    end

    // Next-state and counter update; the 9th shift leaves the fill 1 as stop bit
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_xsr_nxt   = r_xmt_shift_reg;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_xsr_nxt   = {tx_data, 1'b0};
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_state_nxt = DATA;
                w_baud_nxt  = BAUD_ZERO;
                w_bit_nxt   = 4'd0;
            end
            DATA: begin
                if (r_baud_cnt == BIT_LAST) begin
                    w_baud_nxt = BAUD_ZERO;
                    w_bit_nxt  = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd8) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (r_baud_cnt == STOP_LAST) begin
                    w_state_nxt = IDLE;
                    w_baud_nxt  = BAUD_ZERO;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = BAUD_ZERO;
                w_bit_nxt   = 4'd0;
            end
        endcase
    end

    // Line level follows the shift register only while it holds a live frame
    always_comb begin
        tx       = 1'b1;
        start    = 1'b1;
        shift    = 1'b0;
        tx_ready = 1'b0;
        busy     = 1'b1;
        case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD: begin
                start = 1'b0;
            end
            DATA: begin
                tx    = shifted_lsb;
                shift = (r_baud_cnt == BIT_LAST);
            end
            STOP: begin
                tx = shifted_lsb;
            end
            default: begin
                tx = 1'b1;
            end
        endcase
    end

    assign xmt_shift_reg = r_xmt_shift_reg;
    assign tx_done       = r_tx_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural 9-bit shift register on
// each instance (one with one stop bit, one with two).
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, v2;
    logic [7:0] d1, d2;
    logic       ready1, start1, shift1, tx1, busy1, done1;
    logic       ready2, start2, shift2, tx2, busy2, done2;
    logic [8:0] xsr1, xsr2;
    logic [8:0] sr1 = 9'h1FF;
    logic [8:0] sr2 = 9'h1FF;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_ready(ready1),
        .xmt_shift_reg(xsr1), .start(start1), .shift(shift1),
        .shifted_lsb(sr1[0]), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(ready2),
        .xmt_shift_reg(xsr2), .start(start2), .shift(shift2),
        .shifted_lsb(sr2[0]), .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    always_ff @(posedge clk) begin
        if (!start1 && !shift1) sr1 <= xsr1;
        else if (start1 && shift1) sr1 <= {1'b1, sr1[8:1]};
        else sr1 <= sr1;
    end

    always_ff @(posedge clk) begin
        if (!start2 && !shift2) sr2 <= xsr2;
        else if (start2 && shift2) sr2 <= {1'b1, sr2[8:1]};
        else sr2 <= sr2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_tx(input int w);
        return (w == 1) ? tx1 : tx2;
    endfunction
    function automatic logic g_ready(input int w);
        return (w == 1) ? ready1 : ready2;
    endfunction
    function automatic logic g_busy(input int w);
        return (w == 1) ? busy1 : busy2;
    endfunction
    function automatic logic g_done(input int w);
        return (w == 1) ? done1 : done2;
    endfunction
    function automatic logic g_start(input int w);
        return (w == 1) ? start1 : start2;
    endfunction
    function automatic logic g_shift(input int w);
        return (w == 1) ? shift1 : shift2;
    endfunction
    function automatic logic [8:0] g_xsr(input int w);
        return (w == 1) ? xsr1 : xsr2;
    endfunction

    task automatic idle_chk(input int w, input string tag);
        chk({tag, "_tx"},    32'(g_tx(w)),    32'd1);
        chk({tag, "_ready"}, 32'(g_ready(w)), 32'd1);
        chk({tag, "_busy"},  32'(g_busy(w)),  32'd0);
        chk({tag, "_start"}, 32'(g_start(w)), 32'd1);
        chk({tag, "_shift"}, 32'(g_shift(w)), 32'd0);
    endtask

    // Called at the falling edge inside the LOAD cycle; returns at the falling
    // edge inside the tx_done cycle. CLKS_PER_BIT is 4 on both instances.
    task automatic send_frame(input int w, input logic [7:0] d, input int stops,
                              input logic [7:0] mid_d);
        int   nshift;
        int   last;
        logic exp_tx;
        logic exp_sh;
        nshift = 0;
        last   = (9 + stops) * 4 + 1;
        chk("load_xsr",   32'(g_xsr(w)),   32'({d, 1'b0}));
        chk("load_start", 32'(g_start(w)), 32'd0);
        chk("load_shift", 32'(g_shift(w)), 32'd0);
        chk("load_tx",    32'(g_tx(w)),    32'd1);
        chk("load_ready", 32'(g_ready(w)), 32'd0);
        chk("load_busy",  32'(g_busy(w)),  32'd1);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 10) begin
                if (w == 1) d1 = mid_d;
                else d2 = mid_d;
            end
            if (k <= 4) exp_tx = 1'b0;
            else if (k <= 36) exp_tx = d[(k - 1) / 4 - 1];
            else exp_tx = 1'b1;
            exp_sh = ((k % 4) == 0) && (k <= 36);
            if (g_shift(w)) nshift++;
            if (k < last) begin
                chk("frame_tx",    32'(g_tx(w)),    32'(exp_tx));
                chk("frame_shift", 32'(g_shift(w)), 32'(exp_sh));
                chk("frame_ready", 32'(g_ready(w)), 32'd0);
                chk("frame_busy",  32'(g_busy(w)),  32'd1);
                chk("frame_done",  32'(g_done(w)),  32'd0);
                chk("frame_start", 32'(g_start(w)), 32'd1);
            end else begin
                chk("end_done",  32'(g_done(w)),  32'd1);
                chk("end_ready", 32'(g_ready(w)), 32'd1);
                chk("end_busy",  32'(g_busy(w)),  32'd0);
                chk("end_tx",    32'(g_tx(w)),    32'd1);
            end
        end
        chk("shift_count", 32'(nshift), 32'd9);
    endtask

    initial begin
        rst = 1'b0;
        v1 = 1'b0; v2 = 1'b0;
        d1 = 8'h00; d2 = 8'h00;
        #1;
        idle_chk(1, "rst_async");
        chk("rst_xsr",  32'(xsr1),  32'h000);
        chk("rst_done", 32'(done1), 32'd0);
        idle_chk(2, "rst_async2");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_chk(1, "idle");
            chk("idle_done", 32'(done1), 32'd0);
        end

        // 2: single frame 0xA5
        d1 = 8'hA5; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        send_frame(1, 8'hA5, 1, 8'hA5);
        @(negedge clk);
        chk("post_done", 32'(done1), 32'd0);
        idle_chk(1, "post_a5");

        // 3: back-to-back 0x00 then 0xFF with tx_valid held
        d1 = 8'h00; v1 = 1'b1;
        @(negedge clk);
        send_frame(1, 8'h00, 1, 8'hFF);
        @(negedge clk);
        send_frame(1, 8'hFF, 1, 8'hFF);
        v1 = 1'b0;
        @(negedge clk);
        idle_chk(1, "post_b2b");
        chk("post_b2b_done", 32'(done1), 32'd0);

        // 4: two stop bits, 0x3C
        d2 = 8'h3C; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        send_frame(2, 8'h3C, 2, 8'h3C);
        @(negedge clk);
        idle_chk(2, "post_3c");

        // 5: reset during data bit 3 of 0xA5 (that bit is 0 on the line)
        d1 = 8'hA5; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_rst_tx",   32'(tx1),   32'd0);
        chk("pre_rst_busy", 32'(busy1), 32'd1);
        #2 rst = 1'b0;
        #1;
        idle_chk(1, "mid_rst");
        chk("mid_rst_xsr", 32'(xsr1), 32'h000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idle_chk(1, "after_rst");
        d1 = 8'h81; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        send_frame(1, 8'h81, 1, 8'h81);

        // 6: tx_data changes mid-frame; new value only taken once idle
        @(negedge clk);
        d1 = 8'h5A; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        send_frame(1, 8'h5A, 1, 8'hC3);
        @(negedge clk);
        idle_chk(1, "ignored");
        d1 = 8'hC3; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        send_frame(1, 8'hC3, 1, 8'hC3);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Sequencing controller for the UART transmit path's 9-bit shift register (start bit + 8 data bits).
- Accepts a byte over a valid/ready handshake and presents {data, 1'b0} as the shift register's parallel load value.
- Drives the shift register's start/shift control pair and times each bit with a baud counter.
- Generates the idle/stop level on the serial line and flags frame completion.
- Sits between the host-side byte source and the shift register; the serial pin is driven from its tx output.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
tx_valid  input  1  byte available from source
tx_data  input  8  byte to transmit, LSB first on the line
tx_ready  output  1  controller can accept a byte this cycle
xmt_shift_reg  output  9  parallel load value for shift register, {byte, 1'b0}
start  output  1  shift register control, see encoding
shift  output  1  shift register control, see encoding
shifted_lsb  input  1  bit 0 of the shift register output
tx  output  1  serial line
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse, frame complete

Behaviour:
- Shift register control encoding:
  - start=0, shift=0: load xmt_shift_reg.
  - start=1, shift=0: hold.
  - start=1, shift=1: shift right, filling with 1.
  - start=0, shift=1: never driven.
- Reset (rst=0, asynchronous): state=IDLE, baud counter=0, bit counter=0, xmt_shift_reg=9'h000, tx_done=0.
  - Combinational outputs settle immediately: tx=1, tx_ready=1, busy=0, start=1, shift=0.
- FSM states: IDLE, LOAD, DATA, STOP.
- IDLE:
  - Outputs: tx_ready=1, start=1, shift=0, tx=1.
  - On tx_valid=1 at a clock edge: capture xmt_shift_reg <= {tx_data, 1'b0}, go to LOAD.
  - tx_data is not sampled in any other state.
- LOAD: exactly one cycle.
  - Outputs: start=0, shift=0, tx=1, tx_ready=0.
  - Shift register loads on the closing edge.
  - Next state DATA; baud counter=0, bit counter=0.
- DATA:
  - Outputs: start=1, tx=shifted_lsb.
  - Baud counter increments 0..CLKS_PER_BIT-1. When it equals CLKS_PER_BIT-1: shift=1 for that one cycle, counter wraps to 0, bit counter increments.
  - On the 9th shift (bit counter 8 -> 9), go to STOP with counter=0. The shift register LSB now holds the fill 1, which serves as the stop bit.
  - The start bit appears on tx in the first DATA cycle and lasts exactly CLKS_PER_BIT cycles; each data bit likewise.
- STOP:
  - Outputs: start=1, shift=0, tx=shifted_lsb (=1).
  - Counts STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE.
  - tx_done is registered and asserted for exactly the first IDLE cycle.
- busy = (state != IDLE). tx_ready = (state == IDLE).
- Frame latency: the accept edge is followed by 1 LOAD + 9*CLKS_PER_BIT DATA + STOP_BITS*CLKS_PER_BIT STOP cycles, then tx_done.
- Back-to-back: if tx_valid is held high, the next byte is accepted in the same cycle tx_done=1, so there is no idle gap beyond the LOAD cycle.
- tx_valid deasserting while not in IDLE is ignored; accepted data is never dropped.
- Reset mid-frame aborts the frame immediately, tx returns to 1 asynchronously. The shift register's own reset is independent; the line is still forced idle because tx ignores shifted_lsb in IDLE/LOAD.
- Baud counter width: $clog2(STOP_BITS*CLKS_PER_BIT). Bit counter: 4 bits.
- start/shift/tx/tx_ready/busy are combinational decodes of registered state and counters only (no input-to-output paths).

Test Plan:
1. Reset, CLKS_PER_BIT=4, STOP_BITS=1, tx_valid=0 for 20 cycles -> tx=1, tx_ready=1, busy=0, start=1, shift=0 throughout.
2. Send 0xA5 (with shift register attached) -> xmt_shift_reg=9'h14A.
   - tx in 4-cycle bits: 0,1,0,1,0,0,1,0,1 then stop 1.
   - Exactly 9 shift pulses; tx_done pulses 41 cycles after the accept edge.
3. tx_valid held high with 0x00 then 0xFF -> second byte accepted on the tx_done cycle; second frame start bit begins 2 cycles after that edge; tx_ready=0 during frames.
4. STOP_BITS=2, send 0x3C -> stop level lasts 8 cycles; tx_done 45 cycles after accept.
5. Assert rst=0 mid-frame (during data bit 3) -> tx=1 and busy=0 without waiting for a clock edge; after release, a new byte 0x81 transmits correctly.
6. Change tx_data while busy -> transmitted frame is unchanged; the new value is ignored until tx_ready=1.
